// File: rtl/perf_pkg.sv
// Shared types for the pipeline performance monitor: FSM state
// encoding and the packed snapshot width helper.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  function automatic int snap_width(
    input int cyc_w,
    input int num_evt,
    input int cnt_w
  );
    return cyc_w + num_evt * cnt_w;
  endfunction

endpackage

// File: rtl/snap_fifo.sv
// Show-ahead snapshot FIFO with sticky drop flag on overflow.
// Ports: clk_i/rst_n_i, clear_i, push_i+data_i, ready_i (pop),
// valid_o/data_o (head), full_o, drop_o.
module snap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

  // A pop frees the slot, so a push into a full FIFO still lands
  // when the consumer takes the head on the same edge.
  assign do_pop  = ready_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (clear_i) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      drop_d = 1'b0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (push_i && !do_push) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clear_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Gate the head so stale storage never shows while empty.
  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign valid_o = !empty;
  assign full_o  = full;
  assign drop_o  = drop_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle + event counters with limit stop and snapshot FIFO.
// Ports: start/clear/limit/evt/snap in; counters, FSM flags, FIFO out.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int CYC_W   = 32,
  parameter int DEPTH   = 8,
  parameter int SAT     = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  input  logic                           clear_i,
  input  logic [CYC_W-1:0]               limit_i,
  input  logic [NUM_EVT-1:0]             evt_i,
  input  logic                           snap_i,
  output logic [CYC_W-1:0]               cycle_o,
  output logic [NUM_EVT*CNT_W-1:0]       cnt_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic                           snap_valid_o,
  input  logic                           snap_ready_i,
  output logic [CYC_W+NUM_EVT*CNT_W-1:0] snap_data_o,
  output logic                           snap_full_o,
  output logic                           snap_drop_o
);

  localparam int SNAP_W = snap_width(CYC_W, NUM_EVT, CNT_W);

  function automatic logic [CYC_W-1:0] inc_cyc(
    input logic [CYC_W-1:0] v
  );
    if (SAT != 0 && (&v)) return v;
    return v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] inc_cnt(
    input logic [CNT_W-1:0] v
  );
    if (SAT != 0 && (&v)) return v;
    return v + 1'b1;
  endfunction

  perf_state_e              state_q, state_d;
  logic [CYC_W-1:0]         cycle_q, cycle_d;
  logic [NUM_EVT*CNT_W-1:0] cnt_q, cnt_d;
  logic                     done_pushed_q, done_pushed_d;
  logic [CYC_W-1:0]         cycle_nxt;
  logic                     hit_limit;
  logic                     auto_push, manual_push, push;
  logic [SNAP_W-1:0]        push_data;

  assign cycle_nxt = cycle_q + 1'b1;
  assign hit_limit = (limit_i != '0) && (cycle_nxt == limit_i);

  // Auto push fires on the first edge spent in DONE; counters are
  // frozen there, so a coincident manual push carries the same data.
  assign auto_push   = (state_q == ST_DONE) && !done_pushed_q;
  assign manual_push = snap_i && (state_q != ST_IDLE);
  assign push        = (auto_push || manual_push) && !clear_i;
  assign push_data   = {cycle_q, cnt_q};

  always_comb begin
    state_d       = state_q;
    cycle_d       = cycle_q;
    cnt_d         = cnt_q;
    done_pushed_d = done_pushed_q;
    if (clear_i) begin
      state_d       = ST_IDLE;
      cycle_d       = '0;
      cnt_d         = '0;
      done_pushed_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN: begin
          cycle_d = inc_cyc(cycle_q);
          for (int k = 0; k < NUM_EVT; k++) begin
            if (evt_i[k])
              cnt_d[k*CNT_W +: CNT_W] =
                inc_cnt(cnt_q[k*CNT_W +: CNT_W]);
          end
          if (hit_limit)     state_d = ST_DONE;
          else if (!start_i) state_d = ST_IDLE;
        end
        ST_DONE: if (auto_push) done_pushed_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      cycle_q       <= '0;
      cnt_q         <= '0;
      done_pushed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      cnt_q         <= cnt_d;
      done_pushed_q <= done_pushed_d;
    end
  end

  snap_fifo #(
    .WIDTH(SNAP_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_data),
    .ready_i (snap_ready_i),
    .valid_o (snap_valid_o),
    .data_o  (snap_data_o),
    .full_o  (snap_full_o),
    .drop_o  (snap_drop_o)
  );

  assign cycle_o   = cycle_q;
  assign cnt_o     = cnt_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: counting, limit stop,
// pause/clear, FIFO overflow/full push+pop, saturation vs wrap.
module tb_pipe_perf_monitor;

  logic         clk;
  logic         rst_n;
  logic         start, clr, snap, ready;
  logic [31:0]  limit;
  logic [3:0]   evt;
  logic [31:0]  cycle;
  logic [127:0] cnt;
  logic         running, done, valid, full, drop;
  logic [159:0] data;

  logic        s_start, s_evt;
  logic [7:0]  s1_cyc, s0_cyc;
  logic [3:0]  s1_cnt, s0_cnt;
  logic        s1_run, s1_done, s1_val, s1_full, s1_drop;
  logic        s0_run, s0_done, s0_val, s0_full, s0_drop;
  logic [11:0] s1_data, s0_data;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_perf_monitor dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clr),
    .limit_i(limit), .evt_i(evt), .snap_i(snap),
    .cycle_o(cycle), .cnt_o(cnt), .running_o(running),
    .done_o(done), .snap_valid_o(valid), .snap_ready_i(ready),
    .snap_data_o(data), .snap_full_o(full), .snap_drop_o(drop)
  );

  pipe_perf_monitor #(
    .NUM_EVT(1), .CNT_W(4), .CYC_W(8), .DEPTH(2), .SAT(1)
  ) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .clear_i(clr),
    .limit_i(8'd0), .evt_i(s_evt), .snap_i(1'b0),
    .cycle_o(s1_cyc), .cnt_o(s1_cnt), .running_o(s1_run),
    .done_o(s1_done), .snap_valid_o(s1_val), .snap_ready_i(1'b0),
    .snap_data_o(s1_data), .snap_full_o(s1_full),
    .snap_drop_o(s1_drop)
  );

  pipe_perf_monitor #(
    .NUM_EVT(1), .CNT_W(4), .CYC_W(8), .DEPTH(2), .SAT(0)
  ) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .clear_i(clr),
    .limit_i(8'd0), .evt_i(s_evt), .snap_i(1'b0),
    .cycle_o(s0_cyc), .cnt_o(s0_cnt), .running_o(s0_run),
    .done_o(s0_done), .snap_valid_o(s0_val), .snap_ready_i(1'b0),
    .snap_data_o(s0_data), .snap_full_o(s0_full),
    .snap_drop_o(s0_drop)
  );

  task automatic chk(
    input string        tag,
    input logic [159:0] got,
    input logic [159:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; clr = 0; snap = 0; ready = 0;
    limit = '0; evt = '0; s_start = 0; s_evt = 0;
    #2;
    chk("rst_cycle", cycle, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_flags", {running, done, valid, full, drop}, 0);
    chk("rst_data", data, 0);
    #1 rst_n = 1'b1;

    // Basic count: one edge to enter RUN, then 10 counting edges.
    start = 1; evt = 4'b0001;
    tick(1);
    chk("enter_run", {running, cycle}, {1'b1, 32'd0});
    tick(10);
    chk("basic_cycle", cycle, 10);
    chk("basic_cnt", cnt, {96'd0, 32'd10});
    chk("basic_run", running, 1);

    // Pause: the RUN edge that sees start=0 still counts.
    start = 0; evt = 0;
    tick(6);
    chk("pause_cycle", cycle, 11);
    chk("pause_cnt", cnt, {96'd0, 32'd10});
    chk("pause_run", {running, done}, 0);

    clr = 1; tick(1); clr = 0;
    chk("clr_cycle", cycle, 0);
    chk("clr_cnt", cnt, 0);

    // Limit stop at 30 with evt[1] toggling.
    limit = 30; start = 1;
    tick(1);
    for (int i = 0; i < 30; i++) begin
      evt = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    chk("lim_done", {running, done}, 2'b01);
    chk("lim_cycle", cycle, 30);
    chk("lim_cnt", cnt, {64'd0, 32'd15, 32'd0});
    chk("lim_noval", valid, 0);
    evt = 4'b0010;
    tick(1);
    chk("auto_valid", valid, 1);
    chk("auto_data", data, {32'd30, 64'd0, 32'd15, 32'd0});
    tick(3);
    chk("frozen", {cycle, cnt}, {32'd30, 64'd0, 32'd15, 32'd0});
    ready = 1; tick(1); ready = 0;
    tick(2);
    chk("auto_once", valid, 0);

    start = 0; evt = 0; limit = 0;
    clr = 1; tick(1); clr = 0;
    chk("clr2_state", {running, done, valid, drop}, 0);

    // Fill: entries hold pre-edge cycles 0..7.
    start = 1; tick(1);
    snap = 1; tick(8);
    chk("fill_full", {full, drop}, 2'b10);
    // Full push+pop: pop cycle 0, push cycle 8.
    ready = 1; tick(1); ready = 0;
    chk("pp_full", {full, drop}, 2'b10);
    chk("pp_head", data[159:128], 1);
    // Push while full without pop: dropped.
    tick(1); snap = 0;
    chk("ovf_drop", {full, drop}, 2'b11);
    start = 0; tick(1);
    ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_val", valid, 1);
      chk("drain_cyc", data[159:128], 32'(i));
      tick(1);
    end
    ready = 0;
    chk("drain_empty", {valid, full, drop}, 3'b001);

    // Clear empties a populated FIFO and the drop flag.
    start = 1; tick(1);
    snap = 1; tick(2); snap = 0; start = 0;
    tick(1);
    chk("pre_clr_val", valid, 1);
    clr = 1; tick(1); clr = 0;
    chk("clr3", {valid, drop, running, cycle}, 0);

    // Saturation vs wrap on 4-bit counters.
    s_start = 1; s_evt = 1;
    tick(1);
    tick(20);
    chk("sat_cnt", s1_cnt, 15);
    chk("wrap_cnt", s0_cnt, 4);
    chk("sat_cyc", {s1_cyc, s0_cyc}, {8'd20, 8'd20});
    s_start = 0; s_evt = 0;

    // Asynchronous reset mid-run.
    start = 1; evt = 4'b1111; tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {cycle, cnt, running, s1_cnt}, 0);
    #1 rst_n = 1'b1;
    tick(1);
    chk("post_rst", {running, cycle}, {1'b1, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
